// File: rtl/serv_pc_ctrl_pkg.sv
// Shared constants for the serial program-counter control unit.
package serv_pc_ctrl_pkg;

  // Reset strategies, encoded as their four ASCII characters.
  localparam logic [31:0] RST_MINI = "MINI";
  localparam logic [31:0] RST_NONE = "NONE";

  // Default reset vector.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;

  // Architectural PC width.
  localparam int unsigned PC_W = 32;

endpackage

// File: rtl/serv_pc_ctrl_sadd.sv
// One-bit serial full adder; carry is kept across cycles while enabled
// and dropped on the first idle cycle, so each operand stream starts clean.
module serv_pc_ctrl_sadd
  import serv_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_STRATEGY = RST_MINI
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic a_i,
  input  logic b_i,
  output logic sum_o_c
);

  logic cy_q;
  logic cy_d;
  logic cy_c;

  // Sum and carry of the current bit position.
  assign {cy_c, sum_o_c} = 2'(a_i) + 2'(b_i) + 2'(cy_q);
  assign cy_d            = en_i & cy_c;

  generate
    if (RESET_STRATEGY == RST_NONE) begin : g_no_rst
      // Carry flop without reset.
      always_ff @(posedge clk) begin
        cy_q <= cy_d;
      end
    end else begin : g_rst
      // Carry flop, cleared by reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cy_q <= 1'b0;
        else        cy_q <= cy_d;
      end
    end
  endgenerate

endmodule

// File: rtl/serv_pc_ctrl.sv
// Bit-serial PC control: holds the PC and shifts in the next PC LSB first.
module serv_pc_ctrl
  import serv_pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_STRATEGY = RST_MINI,
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter bit          WITH_CSR       = 1'b1,
  parameter int unsigned W              = 1
) (
  input  logic            clk,
  input  logic            i_rst_n,
  input  logic            i_pc_en,
  input  logic            i_cnt12to31,
  input  logic            i_cnt0,
  input  logic            i_cnt1,
  input  logic            i_cnt2,
  input  logic            i_jump,
  input  logic            i_jal_or_jalr,
  input  logic            i_utype,
  input  logic            i_pc_rel,
  input  logic            i_trap,
  input  logic            i_iscomp,
  input  logic [W-1:0]    i_imm,
  input  logic [W-1:0]    i_buf,
  input  logic [W-1:0]    i_csr_pc,
  output logic [W-1:0]    o_rd,
  output logic [W-1:0]    o_bad_pc,
  output logic [PC_W-1:0] o_ibus_adr
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            plus_c;
  logic            p4_c;
  logic            off_a_c;
  logic            off_b_c;
  logic            po_c;
  logic            poa_c;
  logic            new_pc_c;

  // Increment operand: 2 for compressed, 4 otherwise.
  assign plus_c = i_iscomp ? i_cnt1 : i_cnt2;

  serv_pc_ctrl_sadd #(.RESET_STRATEGY(RESET_STRATEGY)) u_inc (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .en_i    (i_pc_en),
    .a_i     (pc_q[0]),
    .b_i     (plus_c),
    .sum_o_c (p4_c)
  );

  // Offset operands: PC-relative base plus upper immediate or buffered target.
  assign off_a_c = i_pc_rel & pc_q[0];
  assign off_b_c = i_utype ? (i_imm[0] & i_cnt12to31) : i_buf[0];

  serv_pc_ctrl_sadd #(.RESET_STRATEGY(RESET_STRATEGY)) u_off (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .en_i    (i_pc_en),
    .a_i     (off_a_c),
    .b_i     (off_b_c),
    .sum_o_c (po_c)
  );

  // Jump targets are always halfword aligned.
  assign poa_c = po_c & ~i_cnt0;

  generate
    if (WITH_CSR) begin : g_csr
      // Trap/mret vector wins over jump; its low two bits are forced to zero.
      always_comb begin
        new_pc_c = p4_c;
        if (i_trap)      new_pc_c = i_csr_pc[0] & ~(i_cnt0 | i_cnt1);
        else if (i_jump) new_pc_c = poa_c;
      end
    end else begin : g_no_csr
      // No trap path: jump target or increment.
      always_comb begin
        new_pc_c = p4_c;
        if (i_jump) new_pc_c = poa_c;
      end
    end
  endgenerate

  // Shift the next-PC bit in at the top while enabled.
  always_comb begin
    pc_d = pc_q;
    if (i_pc_en) pc_d = {new_pc_c, pc_q[PC_W-1:1]};
  end

  generate
    if (RESET_STRATEGY == RST_NONE) begin : g_pc_no_rst
      // PC register without reset.
      always_ff @(posedge clk) begin
        pc_q <= pc_d;
      end
    end else begin : g_pc_rst
      // PC register, loaded with the reset vector.
      always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) pc_q <= RESET_PC;
        else          pc_q <= pc_d;
      end
    end
  endgenerate

  assign o_ibus_adr = pc_q;
  assign o_bad_pc   = W'(poa_c);
  assign o_rd       = W'((i_utype & poa_c) | (i_jal_or_jalr & p4_c));

endmodule

// File: tb/tb_serv_pc_ctrl.sv
// Randomized self-checking bench for serv_pc_ctrl against a word-level model.
module tb_serv_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0064;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_pc_en = 1'b0;
  logic        i_cnt12to31 = 1'b0;
  logic        i_cnt0 = 1'b0;
  logic        i_cnt1 = 1'b0;
  logic        i_cnt2 = 1'b0;
  logic        i_jump = 1'b0;
  logic        i_jal_or_jalr = 1'b0;
  logic        i_utype = 1'b0;
  logic        i_pc_rel = 1'b0;
  logic        i_trap = 1'b0;
  logic        i_iscomp = 1'b0;
  logic [0:0]  i_imm = 1'b0;
  logic [0:0]  i_buf = 1'b0;
  logic [0:0]  i_csr_pc = 1'b0;
  logic [0:0]  o_rd;
  logic [0:0]  o_bad_pc;
  logic [31:0] o_ibus_adr;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  serv_pc_ctrl #(
    .RESET_STRATEGY("MINI"),
    .RESET_PC      (RST_PC),
    .WITH_CSR      (1'b1),
    .W             (1)
  ) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_pc_en      (i_pc_en),
    .i_cnt12to31  (i_cnt12to31),
    .i_cnt0       (i_cnt0),
    .i_cnt1       (i_cnt1),
    .i_cnt2       (i_cnt2),
    .i_jump       (i_jump),
    .i_jal_or_jalr(i_jal_or_jalr),
    .i_utype      (i_utype),
    .i_pc_rel     (i_pc_rel),
    .i_trap       (i_trap),
    .i_iscomp     (i_iscomp),
    .i_imm        (i_imm),
    .i_buf        (i_buf),
    .i_csr_pc     (i_csr_pc),
    .o_rd         (o_rd),
    .o_bad_pc     (o_bad_pc),
    .o_ibus_adr   (o_ibus_adr)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_pc_en = 1'b0; i_cnt0 = 1'b0; i_cnt1 = 1'b0; i_cnt2 = 1'b0; i_cnt12to31 = 1'b0;
    i_jump = 1'b0; i_jal_or_jalr = 1'b0; i_utype = 1'b0; i_pc_rel = 1'b0;
    i_trap = 1'b0; i_iscomp = 1'b0; i_imm = 1'b0; i_buf = 1'b0; i_csr_pc = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    i_rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;
    m_pc = RST_PC;
  endtask

  // Drive one serial cycle of an instruction; sample the serial outputs.
  task automatic drive_cycle(input int i, input logic [31:0] immv, input logic [31:0] bufv,
                             input logic [31:0] csrv, output logic rd_b, output logic bad_b);
    @(negedge clk);
    i_pc_en     = 1'b1;
    i_cnt0      = (i == 0);
    i_cnt1      = (i == 1);
    i_cnt2      = (i == 2);
    i_cnt12to31 = (i >= 12);
    i_imm       = immv[i];
    i_buf       = bufv[i];
    i_csr_pc    = csrv[i];
    #1;
    rd_b  = o_rd[0];
    bad_b = o_bad_pc[0];
  endtask

  // One full instruction, checked against word-level arithmetic.
  task automatic run_instr(input string tag, input bit jump, input bit jal, input bit utype,
                           input bit pcrel, input bit trap, input bit iscomp,
                           input logic [31:0] bufv, input logic [31:0] immv, input logic [31:0] csrv);
    logic [31:0] p4v, offv, poav, exp_rd, exp_pc, rd_s, bad_s;
    logic        rb, bb;
    p4v    = m_pc + (iscomp ? 32'd2 : 32'd4);
    offv   = (pcrel ? m_pc : 32'd0) + (utype ? (immv & 32'hFFFF_F000) : bufv);
    poav   = offv & ~32'd1;
    exp_rd = (utype ? poav : 32'd0) | (jal ? p4v : 32'd0);
    exp_pc = trap ? (csrv & ~32'd3) : (jump ? poav : p4v);
    rd_s   = '0;
    bad_s  = '0;
    @(negedge clk);
    i_jump = jump; i_jal_or_jalr = jal; i_utype = utype;
    i_pc_rel = pcrel; i_trap = trap; i_iscomp = iscomp;
    for (int i = 0; i < 32; i++) begin
      drive_cycle(i, immv, bufv, csrv, rb, bb);
      rd_s[i]  = rb;
      bad_s[i] = bb;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    check({tag, ".pc"}, o_ibus_adr, exp_pc);
    check({tag, ".rd"}, rd_s, exp_rd);
    check({tag, ".bad_pc"}, bad_s, poav);
    m_pc = exp_pc;
  endtask

  initial begin
    logic rb, bb;
    m_pc = RST_PC;

    // Reset held for two clocks, then released with the shift disabled.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold", o_ibus_adr, RST_PC);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_stable", o_ibus_adr, RST_PC);

    run_instr("pc_plus4", 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    check("pc_plus4_val", m_pc, 32'h68);
    repeat (2) @(negedge clk);
    check("idle_hold", o_ibus_adr, 32'h68);

    do_reset();
    run_instr("pc_plus2_jal", 0, 1, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
    check("pc_plus2_val", m_pc, 32'h66);

    do_reset();
    run_instr("jump", 1, 0, 0, 0, 0, 0, 32'h0000_0101, 32'h0, 32'h0);
    check("jump_val", m_pc, 32'h100);

    do_reset();
    run_instr("auipc", 0, 0, 1, 1, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'h0);
    check("auipc_pc", m_pc, 32'h68);

    do_reset();
    run_instr("trap_jump", 1, 0, 0, 0, 1, 0, 32'h0000_0101, 32'h0, 32'h0000_0203);
    check("trap_val", m_pc, 32'h200);

    // Reset mid-shift with a live offset carry, then a jump that would see a stale carry.
    do_reset();
    @(negedge clk);
    i_jump = 1'b1; i_pc_rel = 1'b1;
    for (int i = 0; i < 10; i++) drive_cycle(i, 32'h0, 32'hFFFF_FFFF, 32'h0, rb, bb);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("reset_mid_shift", o_ibus_adr, RST_PC);
    @(posedge clk);
    #2;
    i_rst_n = 1'b1;
    m_pc = RST_PC;
    run_instr("post_abort", 1, 0, 0, 0, 0, 0, 32'h0000_0100, 32'h0, 32'h0);

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++) begin
      bit jump, jal, utype, pcrel, trap, iscomp;
      jump   = 1'($urandom_range(0, 1));
      jal    = 1'($urandom_range(0, 1));
      utype  = 1'($urandom_range(0, 1));
      pcrel  = 1'($urandom_range(0, 1));
      trap   = ($urandom_range(0, 5) == 0);
      iscomp = 1'($urandom_range(0, 1));
      run_instr("rand", jump, jal, utype, pcrel, trap, iscomp, $urandom, $urandom, $urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serv_pc_ctrl.md
Name: serv_pc_ctrl

Overview:
- Bit-serial program-counter control unit of the SERV RISC-V core.
- Holds the 32-bit PC and drives it onto the instruction-bus address.
- Each instruction, shifts in the next PC one bit per enabled cycle, LSB first, over 32 cycles: PC+4, PC+2, PC+offset or a CSR trap vector.
- Also streams link/AUIPC results to the rd path and the misaligned-target address to CSR logic.

Parameters:
- RESET_STRATEGY, "MINI": "MINI" resets PC and carry flops; "NONE" resets nothing.
- RESET_PC, 32'd0: PC value loaded on reset.
- WITH_CSR, 1: 1 enables the trap path; 0 removes it, and i_trap/i_csr_pc are ignored.
- W, 1: serial datapath width; only 1 is legal.

Ports:
- clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_pc_en  in  1  shift-enable for PC and carry flops
- i_cnt12to31  in  1  serial counter in bits 12..31
- i_cnt0  in  1  serial counter at bit 0
- i_cnt1  in  1  serial counter at bit 1
- i_cnt2  in  1  serial counter at bit 2
- i_jump  in  1  take branch/jump target
- i_jal_or_jalr  in  1  rd receives PC+4/PC+2
- i_utype  in  1  LUI/AUIPC: offset from immediate; rd receives offset sum
- i_pc_rel  in  1  offset is relative to PC (AUIPC/branch/JAL)
- i_trap  in  1  trap/mret: next PC from CSR
- i_iscomp  in  1  current instruction is compressed
- i_imm  in  W  serial immediate bit
- i_buf  in  W  serial rs1+imm / branch-target bit
- i_csr_pc  in  W  serial trap-vector/mepc bit
- o_rd  out  W  serial rd write data
- o_bad_pc  out  W  serial aligned jump target, for mtval
- o_ibus_adr  out  32  current PC

Behaviour:
- Reset (i_rst_n low, asynchronous, MINI): PC = RESET_PC, both carry flops = 0.
  - o_ibus_adr = RESET_PC while reset is held.
  - Reset asserted mid-instruction aborts the shift immediately.
- o_ibus_adr = PC register, combinational.
- Increment adder (combinational):
  - plus = i_iscomp ? i_cnt1 : i_cnt2.
  - {cy4, p4} = PC[0] + plus + cy4_r.
  - Clock edge: cy4_r <= i_pc_en & cy4.
- Offset adder (combinational):
  - a = i_pc_rel & PC[0].
  - b = i_utype ? (i_imm & i_cnt12to31) : i_buf.
  - {cyo, po} = a + b + cyo_r.
  - Clock edge: cyo_r <= i_pc_en & cyo.
- Aligned offset: poa = po & ~i_cnt0. Forces target bit 0 to 0.
- Next-PC bit new_pc:
  - If WITH_CSR and i_trap: i_csr_pc & ~(i_cnt0 | i_cnt1).
  - Else if i_jump: poa.
  - Else: p4.
- Clock edge with i_pc_en = 1: PC <= {new_pc, PC[31:1]}.
- Clock edge with i_pc_en = 0: PC holds.
- After 32 enabled cycles, PC equals the new value.
- o_rd = (i_utype & poa) | (i_jal_or_jalr & p4), combinational.
- o_bad_pc = poa.
- Simultaneous i_trap and i_jump: trap wins.
- Carry flops clear automatically on the first cycle with i_pc_en = 0. No explicit clear is needed between instructions.
- PC arithmetic wraps modulo 2^32; the final carry is discarded.

Decomposition:
- Shared package: RESET_STRATEGY string constants ("MINI", "NONE") and the default reset-vector constant.
- One sub-module is natural: serv_pc_ctrl_sadd, a 1-bit serial full adder with carry flop, asynchronous active-low reset and enable-gated carry. Instantiate it twice (increment and offset).
- PC register and next-PC mux stay in the top module.

Test Plan:
- Reset: RESET_PC = 0x64, i_rst_n low for 2 clocks, then high with i_pc_en = 0 -> o_ibus_adr = 0x00000064 and stable.
- PC+4: i_pc_en = 1 for 32 cycles, i_cnt0/1/2 one-hot at cycles 0/1/2, i_iscomp = 0, i_jump = i_trap = 0 -> o_ibus_adr = 0x68.
- PC+2: same sequence with i_iscomp = 1 -> 0x64 becomes 0x66. With i_jal_or_jalr = 1, o_rd serially streams 0x66.
- Jump:
  - i_jump = 1, i_buf streams 0x00000101 -> PC = 0x100 (bit 0 masked).
  - Same stimulus -> o_bad_pc streams 0x100.
- AUIPC: PC = 0x64, i_utype = i_pc_rel = 1, i_imm all ones, i_cnt12to31 in cycles 12..31 -> o_rd streams 0x64 + 0xFFFFF000 = 0xFFFFF064 while PC advances to 0x68.
- Trap/reset-mid-shift:
  - i_trap = 1 and i_jump = 1, i_csr_pc streams 0x00000203 -> PC = 0x200.
  - i_rst_n pulsed low at cycle 10 of a shift -> PC = 0x64 immediately; carries cleared.
